// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int MEM_LATENCY_DEF = 4;
  // Wide enough for a latency count of up to 15 cycles.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational two-way grant selection between the I-cache and the D-cache.
// Build option MEM_ARB_DCACHE_PRIORITY_EN: D wins every tie, with no
// last-grant history. Without it, ties go to whichever side did not win last.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
`else
  input  grant_t last_grant,
`endif
  output grant_t grant
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    grant = GNT_I;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    if (d_req) grant = GNT_D;
`else
    if (d_req && (!i_req || last_grant == GNT_I)) grant = GNT_D;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between the I-cache and the D-cache.
// A winning request is latched, issued for one cycle, and the latency is
// counted out. Read data and a one-cycle done pulse then return to the winner.
// Build option MEM_ARB_DCACHE_PRIORITY_EN selects fixed D-cache priority
// instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  grant_t           owner;
  grant_t           pick;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
`else
  grant_t           last_grant;
`endif

  mem_arb_picker u_picker (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
`else
    .last_grant (last_grant),
`endif
    .grant      (pick)
  );

  // Transaction FSM. mem_address and mem_data_in double as the latched
  // request, so they hold the winner's values for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= GNT_I;
      lat_we       <= 1'b0;
      cnt          <= '0;
      mem_address  <= '0;
      mem_write_en <= 1'b0;
      mem_data_in  <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
`else
      last_grant   <= GNT_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner <= pick;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
`else
            last_grant <= pick;
`endif
            if (pick == GNT_D) begin
              lat_we       <= d_we;
              mem_write_en <= d_we;
              mem_address  <= d_addr;
              mem_data_in  <= d_wdata;
            end else begin
              lat_we       <= i_we;
              mem_write_en <= i_we;
              mem_address  <= i_addr;
              mem_data_in  <= i_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_write_en <= 1'b0;
          cnt          <= CNT_LOAD;
          state        <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (owner == GNT_D) d_rdata <= mem_data_out;
              else                i_rdata <= mem_data_out;
            end
            if (owner == GNT_D) d_done <= 1'b1;
            else                i_done <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
